// File: rtl/grid_mem_arbiter_if.sv
// Grid RAM arbiter bus: controller and display request channels, clear
// control, and the registered single-port RAM interface.
interface grid_mem_arbiter_if #(
  parameter int COORD_W = 16,
  parameter int CELL_W  = 4,
  parameter int ADDR_W  = 10
);
  logic               clear_req;
  logic               clear_busy;

  logic               ctl_req;
  logic               ctl_we;
  logic [COORD_W-1:0] ctl_x;
  logic [COORD_W-1:0] ctl_y;
  logic [CELL_W-1:0]  ctl_wdata;
  logic               ctl_ack;
  logic [CELL_W-1:0]  ctl_rdata;

  logic               disp_req;
  logic [COORD_W-1:0] disp_x;
  logic [COORD_W-1:0] disp_y;
  logic               disp_ack;
  logic [CELL_W-1:0]  disp_rdata;

  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [CELL_W-1:0]  mem_wdata;
  logic [CELL_W-1:0]  mem_rdata;

  // Arbiter side.
  modport slave (
    input  clear_req, ctl_req, ctl_we, ctl_x, ctl_y, ctl_wdata,
           disp_req, disp_x, disp_y, mem_rdata,
    output clear_busy, ctl_ack, ctl_rdata, disp_ack, disp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / RAM side.
  modport master (
    output clear_req, ctl_req, ctl_we, ctl_x, ctl_y, ctl_wdata,
           disp_req, disp_x, disp_y, mem_rdata,
    input  clear_busy, ctl_ack, ctl_rdata, disp_ack, disp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Owner of the single-port grid RAM. Arbitrates the game controller
// (read/write) and display scanner (read-only) round-robin, maps
// out-of-grid accesses to ROCK, and zero-fills the grid on clear_req.
// Pipeline: grant in N -> mem_* in N+1 -> ack/rdata in N+2.
module grid_mem_arbiter #(
  parameter int GRID_X  = 32,
  parameter int GRID_Y  = 24,
  parameter int CELL_W  = 4,
  parameter int COORD_W = 16
) (
  input logic               clk,
  input logic               rst,
  grid_mem_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(GRID_X * GRID_Y);
  localparam int X_W    = $clog2(GRID_X);
  localparam int Y_W    = ADDR_W - X_W;
  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(GRID_X);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(GRID_Y);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_X * GRID_Y - 1);
  localparam logic [CELL_W-1:0]  CELL_ROCK = CELL_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                rr_disp_q, rr_disp_d;    // 1: display wins next contention
  logic                grant_ctl, grant_disp;

  logic                s1_valid_q, s1_disp_q, s1_oor_q;
  logic                ctl_ack_q, disp_ack_q, ack_oor_q;
  logic [CELL_W-1:0]   ctl_rdata_q, disp_rdata_q;

  logic                mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [CELL_W-1:0]   mem_wdata_d;
  logic                sel_oor;

  logic                ctl_oor, disp_oor, ctl_elig, disp_elig, in_flight;
  logic [ADDR_W-1:0]   ctl_addr, disp_addr;
  logic [CELL_W-1:0]   ack_data;

  // Upper coordinate bits only matter for the range check.
  assign ctl_oor   = (bus.ctl_x >= X_LIM) || (bus.ctl_y >= Y_LIM);
  assign disp_oor  = (bus.disp_x >= X_LIM) || (bus.disp_y >= Y_LIM);
  assign ctl_addr  = {bus.ctl_y[Y_W-1:0], bus.ctl_x[X_W-1:0]};
  assign disp_addr = {bus.disp_y[Y_W-1:0], bus.disp_x[X_W-1:0]};

  // A requester is busy from its grant until its ack cycle inclusive.
  assign ctl_elig  = bus.ctl_req  && !((s1_valid_q && !s1_disp_q) || ctl_ack_q);
  assign disp_elig = bus.disp_req && !((s1_valid_q &&  s1_disp_q) || disp_ack_q);
  assign in_flight = s1_valid_q || ctl_ack_q || disp_ack_q;

  // Next state, arbitration and next RAM command.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_disp_d   = rr_disp_q;
    grant_ctl   = 1'b0;
    grant_disp  = 1'b0;
    sel_oor     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d = S_DRAIN;
        end else if (ctl_elig && disp_elig) begin
          grant_ctl  = !rr_disp_q;
          grant_disp = rr_disp_q;
          rr_disp_d  = !rr_disp_q;
        end else begin
          grant_ctl  = ctl_elig;
          grant_disp = disp_elig;
        end
        if (grant_ctl) begin
          sel_oor     = ctl_oor;
          mem_en_d    = !ctl_oor;
          mem_we_d    = bus.ctl_we && !ctl_oor;
          mem_addr_d  = ctl_addr;
          mem_wdata_d = bus.ctl_wdata;
        end else if (grant_disp) begin
          sel_oor    = disp_oor;
          mem_en_d   = !disp_oor;
          mem_addr_d = disp_addr;
        end
      end
      S_DRAIN: begin
        if (!in_flight) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        mem_en_d   = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = clr_cnt_q;
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pipeline and RAM command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      rr_disp_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_disp_q     <= 1'b0;
      s1_oor_q      <= 1'b0;
      ctl_ack_q     <= 1'b0;
      disp_ack_q    <= 1'b0;
      ack_oor_q     <= 1'b0;
      ctl_rdata_q   <= '0;
      disp_rdata_q  <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, like real flops.
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      rr_disp_q     <= rr_disp_d;
      s1_valid_q    <= grant_ctl || grant_disp;
      s1_disp_q     <= grant_disp;
      s1_oor_q      <= sel_oor;
      ctl_ack_q     <= s1_valid_q && !s1_disp_q;
      disp_ack_q    <= s1_valid_q && s1_disp_q;
      ack_oor_q     <= s1_oor_q;
      if (ctl_ack_q)  ctl_rdata_q  <= ack_data;
      if (disp_ack_q) disp_rdata_q <= ack_data;
      bus.mem_en    <= mem_en_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
    end
  end

  // RAM data arrives in the ack cycle; outside it the last value is held.
  assign ack_data       = ack_oor_q ? CELL_ROCK : bus.mem_rdata;
  assign bus.ctl_ack    = ctl_ack_q;
  assign bus.disp_ack   = disp_ack_q;
  assign bus.ctl_rdata  = ctl_ack_q  ? ack_data : ctl_rdata_q;
  assign bus.disp_rdata = disp_ack_q ? ack_data : disp_rdata_q;
  assign bus.clear_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a behavioural sync RAM.
module tb_grid_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  grid_mem_arbiter_if bus ();
  grid_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Sync-read RAM; fill_ram loads a nonzero pattern in one cycle.
  logic [3:0] ram [768];
  logic [3:0] ram_rd = '0;
  bit         fill_ram = 1'b0;
  always @(posedge clk) begin
    if (fill_ram) begin
      for (int i = 0; i < 768; i++) ram[i] <= 4'((i % 15) + 1);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rd <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rd;

  typedef struct {
    bit         port;      // 0 ctl, 1 disp
    bit         we;
    logic [15:0] x, y;
    logic [3:0]  wdata;
    bit          exp_en;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_rdata;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(bit port, bit we, logic [15:0] x, logic [15:0] y,
                              logic [3:0] wd, bit en, logic [9:0] addr, logic [3:0] rd);
    vec_t v;
    v.port = port; v.we = we; v.x = x; v.y = y; v.wdata = wd;
    v.exp_en = en; v.exp_addr = addr; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},     32'(bus.mem_en),     0);
    check({tag, "_mem_we"},     32'(bus.mem_we),     0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr),   0);
    check({tag, "_mem_wdata"},  32'(bus.mem_wdata),  0);
    check({tag, "_clear_busy"}, 32'(bus.clear_busy), 0);
    check({tag, "_ctl_ack"},    32'(bus.ctl_ack),    0);
    check({tag, "_disp_ack"},   32'(bus.disp_ack),   0);
    check({tag, "_ctl_rdata"},  32'(bus.ctl_rdata),  0);
    check({tag, "_disp_rdata"}, 32'(bus.disp_rdata), 0);
  endtask

  // One isolated access: drive, check RAM command, ack, then rdata hold.
  task automatic apply_vec(input int idx, input vec_t v);
    string n;
    logic [3:0] rd;
    n = $sformatf("vec%0d", idx);
    if (v.port == 1'b0) begin
      bus.ctl_req = 1'b1; bus.ctl_we = v.we; bus.ctl_x = v.x; bus.ctl_y = v.y;
      bus.ctl_wdata = v.wdata;
    end else begin
      bus.disp_req = 1'b1; bus.disp_x = v.x; bus.disp_y = v.y;
    end
    step();
    check({n, "_mem_en"}, 32'(bus.mem_en), 32'(v.exp_en));
    if (v.exp_en) begin
      check({n, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.exp_addr));
      check({n, "_mem_we"},   32'(bus.mem_we),   32'(v.we));
      if (v.we) check({n, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
    end
    step();
    check({n, "_ctl_ack"},  32'(bus.ctl_ack),  32'(v.port == 1'b0));
    check({n, "_disp_ack"}, 32'(bus.disp_ack), 32'(v.port == 1'b1));
    if (!v.we) begin
      rd = v.port ? bus.disp_rdata : bus.ctl_rdata;
      check({n, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
    end
    bus.ctl_req = 1'b0; bus.disp_req = 1'b0;
    step();
    if (!v.we) begin
      rd = v.port ? bus.disp_rdata : bus.ctl_rdata;
      check({n, "_rdata_hold"}, 32'(rd), 32'(v.exp_rdata));
    end
  endtask

  initial begin
    int bad_cycles, bad_busy, bad_cells, dack_seen, guard;
    bit done;

    vecs[0]  = mk(0, 1, 15, 15, 1, 1, 495, 0);
    vecs[1]  = mk(0, 0, 15, 15, 0, 1, 495, 1);
    vecs[2]  = mk(0, 0, 32, 5,  0, 0, 0,   2);
    vecs[3]  = mk(0, 0, 3,  24, 0, 0, 0,   2);
    vecs[4]  = mk(0, 1, 0,  0,  4, 1, 0,   0);
    vecs[5]  = mk(0, 0, 0,  0,  0, 1, 0,   4);
    vecs[6]  = mk(0, 1, 31, 23, 2, 1, 767, 0);
    vecs[7]  = mk(1, 0, 31, 23, 0, 1, 767, 2);
    vecs[8]  = mk(0, 1, 16'h8001, 0, 5, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1,  0,  0, 1, 1,   0);
    vecs[10] = mk(0, 1, 31, 24, 7, 0, 0,   0);
    vecs[11] = mk(1, 0, 31, 23, 0, 1, 767, 2);
    vecs[12] = mk(1, 0, 0, 16'h0100, 0, 0, 0, 2);
    vecs[13] = mk(1, 0, 15, 15, 0, 1, 495, 1);

    rst = 1'b1;
    bus.clear_req = 0; bus.ctl_req = 0; bus.ctl_we = 0; bus.ctl_x = 0; bus.ctl_y = 0;
    bus.ctl_wdata = 0; bus.disp_req = 0; bus.disp_x = 0; bus.disp_y = 0;
    fill_ram = 1'b1;
    step();
    step();
    fill_ram = 1'b0;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // T1: full clear.
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    check("t1_busy_drain", 32'(bus.clear_busy), 1);
    check("t1_en_drain",   32'(bus.mem_en), 0);
    step();
    check("t1_en_clear_entry", 32'(bus.mem_en), 0);
    step();
    bad_cycles = 0; bad_busy = 0;
    for (int i = 0; i < 768; i++) begin
      if (!(bus.mem_en === 1'b1 && bus.mem_we === 1'b1 && bus.mem_wdata === 4'd0 &&
            bus.mem_addr === 10'(i))) bad_cycles++;
      if (i < 767 && bus.clear_busy !== 1'b1) bad_busy++;
      if (i == 767) check("t1_busy_last", 32'(bus.clear_busy), 0);
      else step();
    end
    check("t1_write_seq_bad_cycles", 32'(bad_cycles), 0);
    check("t1_busy_bad_cycles", 32'(bad_busy), 0);
    step();
    check("t1_en_after", 32'(bus.mem_en), 0);
    bad_cells = 0;
    for (int i = 0; i < 768; i++) if (ram[i] !== 4'd0) bad_cells++;
    check("t1_ram_nonzero_cells", 32'(bad_cells), 0);

    // T2/T3 and range cases: isolated accesses.
    for (int i = 0; i < 14; i++) apply_vec(i, vecs[i]);

    // T4: both requesters held; grants alternate ctl, disp, idle.
    bus.ctl_req = 1'b1; bus.ctl_we = 1'b0; bus.ctl_x = 15; bus.ctl_y = 15;
    bus.disp_req = 1'b1; bus.disp_x = 31; bus.disp_y = 23;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("t4_k%0d_en", k), 32'(bus.mem_en), 32'(k % 3 != 0));
      if (k % 3 == 1) check($sformatf("t4_k%0d_addr", k), 32'(bus.mem_addr), 495);
      if (k % 3 == 2) check($sformatf("t4_k%0d_addr", k), 32'(bus.mem_addr), 767);
      check($sformatf("t4_k%0d_ctl_ack", k),  32'(bus.ctl_ack),  32'(k % 3 == 2));
      check($sformatf("t4_k%0d_disp_ack", k), 32'(bus.disp_ack), 32'(k % 3 == 0));
      if (k % 3 == 2) check($sformatf("t4_k%0d_ctl_rdata", k), 32'(bus.ctl_rdata), 1);
      if (k % 3 == 0) check($sformatf("t4_k%0d_disp_rdata", k), 32'(bus.disp_rdata), 2);
      if (k == 9) begin bus.ctl_req = 1'b0; bus.disp_req = 1'b0; end
    end
    step();
    check("t4_quiet_en", 32'(bus.mem_en), 0);

    // Pointer moved to disp by the last contended grant.
    bus.ctl_req = 1'b1; bus.disp_req = 1'b1;
    step();
    check("rr_first_addr", 32'(bus.mem_addr), 767);
    step();
    check("rr_second_addr", 32'(bus.mem_addr), 495);
    check("rr_disp_ack", 32'(bus.disp_ack), 1);
    step();
    check("rr_ctl_ack", 32'(bus.ctl_ack), 1);
    bus.ctl_req = 1'b0; bus.disp_req = 1'b0;
    step();
    step();

    // T5: clear raised the cycle after a ctl grant; disp waits out the clear.
    bus.ctl_req = 1'b1; bus.ctl_we = 1'b0; bus.ctl_x = 15; bus.ctl_y = 15;
    step();
    check("t5_ctl_mem_addr", 32'(bus.mem_addr), 495);
    bus.clear_req = 1'b1;
    bus.disp_req = 1'b1; bus.disp_x = 31; bus.disp_y = 23;
    step();
    check("t5_ctl_ack",   32'(bus.ctl_ack), 1);
    check("t5_ctl_rdata", 32'(bus.ctl_rdata), 1);
    check("t5_busy",      32'(bus.clear_busy), 1);
    bus.ctl_req = 1'b0; bus.clear_req = 1'b0;
    dack_seen = 0; done = 1'b0; guard = 0;
    while (!done && guard < 1000) begin
      step();
      guard++;
      if (bus.disp_ack) dack_seen++;
      if (!bus.clear_busy) done = 1'b1;
    end
    check("t5_clear_finished", 32'(done), 1);
    check("t5_disp_ack_during_clear", 32'(dack_seen), 0);
    step();
    check("t5_disp_mem_en",   32'(bus.mem_en), 1);
    check("t5_disp_mem_we",   32'(bus.mem_we), 0);
    check("t5_disp_mem_addr", 32'(bus.mem_addr), 767);
    check("t5_disp_ack_early", 32'(bus.disp_ack), 0);
    step();
    check("t5_disp_ack",   32'(bus.disp_ack), 1);
    check("t5_disp_rdata", 32'(bus.disp_rdata), 0);
    bus.disp_req = 1'b0;
    step();

    // T6: reset in the middle of a clear at address 300.
    fill_ram = 1'b1;
    step();
    fill_ram = 1'b0;
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    done = 1'b0; guard = 0;
    while (!done && guard < 1000) begin
      step();
      guard++;
      if (bus.mem_en === 1'b1 && bus.mem_addr === 10'd300) done = 1'b1;
    end
    check("t6_reached_addr300", 32'(done), 1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    step();
    step();
    rst = 1'b0;
    step();
    check("t6_idle_busy", 32'(bus.clear_busy), 0);
    check("t6_idle_en",   32'(bus.mem_en), 0);
    bad_cells = 0;
    for (int i = 0; i < 300; i++) if (ram[i] !== 4'd0) bad_cells++;
    check("t6_cleared_low_cells", 32'(bad_cells), 0);
    bad_cells = 0;
    for (int i = 300; i < 768; i++) if (ram[i] !== 4'((i % 15) + 1)) bad_cells++;
    check("t6_untouched_high_cells", 32'(bad_cells), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
